// File: rtl/sfifo_pkg.sv
// sfifo_pkg: default sizing constants and pointer/count width helpers
// shared by the synchronous FIFO, its storage and its bus interface.
package sfifo_pkg;

    localparam int unsigned DEF_WIDTH     = 8;
    localparam int unsigned DEF_DEPTH     = 8;
    localparam int unsigned DEF_AE_THRESH = 1;

    // Address width for a power-of-two depth (at least one bit).
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy width: one extra bit so the value DEPTH is representable.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sfifo_if.sv
// sfifo_if: request/data/status bundle of the synchronous FIFO.
// master = producer/consumer side, slave = FIFO side.
interface sfifo_if
    import sfifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
);
    localparam int unsigned CW = cnt_w(DEPTH);

    logic             clr;
    logic             wen;
    logic [WIDTH-1:0] data;
    logic             ren;
    logic [WIDTH-1:0] out;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output clr, wen, data, ren,
        input  out, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );

    modport slave (
        input  clr, wen, data, ren,
        output out, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );

endinterface

// File: rtl/sfifo_mem.sv
// sfifo_mem: simple dual-port storage, synchronous write, asynchronous
// read, deliberately without reset.
module sfifo_mem
    import sfifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [ptr_w(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]        wdata,
    input  logic [ptr_w(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]        rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port: store one word per accepted write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sfifo.sv
// sfifo: synchronous FIFO controller (pointers, occupancy, status flags,
// sticky error flags, output register) around sfifo_mem.
// Define SFIFO_FWFT_EN for first-word-fall-through output; otherwise the
// output is registered and loads on each accepted read.
module sfifo
    import sfifo_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = DEF_AE_THRESH
) (
    input  logic    clk,
    input  logic    rst,
    sfifo_if.slave  bus
);

    localparam int unsigned AW = ptr_w(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);

    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_acc, rd_acc, mem_we;
    logic             full, empty;
    logic [WIDTH-1:0] rd_data;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Accept decisions, pointer/count/error next state; clr overrides all.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        // A simultaneous read frees the slot, so a full FIFO still takes the write.
        wr_acc      = bus.wen && (!full || bus.ren);
        rd_acc      = bus.ren && !empty;
        mem_we      = 1'b0;
        if (bus.clr) begin
            wptr_d      = '0;
            rptr_d      = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            mem_we = wr_acc;
            if (wr_acc) begin
                wptr_d = wptr_q + AW'(1);
            end
            if (rd_acc) begin
                rptr_d = rptr_q + AW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            overflow_d  = overflow_q  | (bus.wen && !wr_acc);
            underflow_d = underflow_q | (bus.ren && !rd_acc);
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    sfifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wptr_q),
        .wdata (bus.data),
        .raddr (rptr_q),
        .rdata (rd_data)
    );

`ifdef SFIFO_FWFT_EN
    // Head word is presented directly; nothing valid to show when empty.
    assign bus.out = empty ? '0 : rd_data;
`else
    logic [WIDTH-1:0] out_q, out_d;

    // Output word: load head on accepted read, clear on flush, else hold.
    always_comb begin
        out_d = out_q;
        if (bus.clr) begin
            out_d = '0;
        end else if (rd_acc) begin
            out_d = rd_data;
        end
    end

    // Output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign bus.out = out_q;
`endif

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= CW'(AF_THRESH));
    assign bus.almost_empty = (count_q <= CW'(AE_THRESH));
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sfifo.sv
// tb_sfifo: directed and randomized bench for sfifo (WIDTH=8, DEPTH=4,
// AF_THRESH=3, AE_THRESH=1) against a queue-based reference model.
module tb_sfifo;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AF    = 3;
    localparam int unsigned AE    = 1;

    logic clk;
    logic rst;
    bit   chk_en;

    int checks;
    int errors;

    // reference model state
    logic [7:0] mq[$];
    logic [7:0] m_out;
    bit         m_ovf;
    bit         m_unf;

    sfifo_if #(.WIDTH(8), .DEPTH(DEPTH)) bus ();

    sfifo #(
        .WIDTH     (8),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_out();
`ifdef SFIFO_FWFT_EN
        return (mq.size() > 0) ? mq[0] : 8'h00;
`else
        return m_out;
`endif
    endfunction

    task automatic model_reset();
        mq.delete();
        m_out = 8'h00;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_edge(input bit w, input bit r, input logic [7:0] d, input bit c);
        bit rd_ok, wr_ok;
        if (c) begin
            model_reset();
        end else begin
            rd_ok = r && (mq.size() > 0);
            wr_ok = w && ((mq.size() < DEPTH) || r);
            if (w && !wr_ok) m_ovf = 1'b1;
            if (r && !rd_ok) m_unf = 1'b1;
            if (rd_ok) m_out = mq.pop_front();
            if (wr_ok) mq.push_back(d);
        end
    endtask

    task automatic step(input bit w, input bit r, input logic [7:0] d, input bit c);
        bus.wen  = w;
        bus.ren  = r;
        bus.data = d;
        bus.clr  = c;
        @(posedge clk);
        if (rst) model_edge(w, r, d, c);
        #1;
    endtask

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("out",          bus.out,          exp_out());
            check("count",        bus.count,        mq.size());
            check("full",         bus.full,         mq.size() == DEPTH);
            check("empty",        bus.empty,        mq.size() == 0);
            check("almost_full",  bus.almost_full,  mq.size() >= AF);
            check("almost_empty", bus.almost_empty, mq.size() <= AE);
            check("overflow",     bus.overflow,     m_ovf);
            check("underflow",    bus.underflow,    m_unf);
        end
    end

    initial begin
        logic [7:0] wr_words[4];
        int unsigned pw;
        int unsigned pr;
        wr_words[0] = 8'h11;
        wr_words[1] = 8'h22;
        wr_words[2] = 8'h33;
        wr_words[3] = 8'h44;
        checks   = 0;
        errors   = 0;
        chk_en   = 1'b0;
        bus.wen  = 1'b0;
        bus.ren  = 1'b0;
        bus.clr  = 1'b0;
        bus.data = 8'h00;
        model_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        #1 chk_en = 1'b1;

        // reset state
        check("rst_count", bus.count, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_full",  bus.full, 0);
        check("rst_ae",    bus.almost_empty, 1);
        check("rst_af",    bus.almost_full, 0);
        check("rst_out",   bus.out, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // fill: occupancy and thresholds
        step(1'b1, 1'b0, 8'h11, 1'b0);
        check("fill1_count", bus.count, 1);
        check("fill1_ae",    bus.almost_empty, 1);
        step(1'b1, 1'b0, 8'h22, 1'b0);
        check("fill2_count", bus.count, 2);
        check("fill2_ae",    bus.almost_empty, 0);
        step(1'b1, 1'b0, 8'h33, 1'b0);
        check("fill3_count", bus.count, 3);
        check("fill3_af",    bus.almost_full, 1);
        check("fill3_full",  bus.full, 0);
        step(1'b1, 1'b0, 8'h44, 1'b0);
        check("fill4_count", bus.count, 4);
        check("fill4_full",  bus.full, 1);

        // write into full FIFO is dropped
        step(1'b1, 1'b0, 8'h55, 1'b0);
        check("ovf_flag",  bus.overflow, 1);
        check("ovf_count", bus.count, 4);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0);
`ifndef SFIFO_FWFT_EN
            check("drain_out", bus.out, wr_words[i]);
`endif
        end
        check("drain_empty", bus.empty, 1);

        // full with simultaneous write and read, then drain across wrap
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, wr_words[i], 1'b0);
        step(1'b1, 1'b1, 8'h66, 1'b0);
        check("fullrw_count", bus.count, 4);
        check("fullrw_ovf",   bus.overflow, 1);
`ifndef SFIFO_FWFT_EN
        check("fullrw_out",   bus.out, 8'h11);
`endif
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
`ifndef SFIFO_FWFT_EN
        check("wrap_last_out", bus.out, 8'h66);
`endif

        // empty with simultaneous write and read
        step(1'b1, 1'b1, 8'h77, 1'b0);
        check("emptyrw_unf",   bus.underflow, 1);
        check("emptyrw_count", bus.count, 1);
`ifndef SFIFO_FWFT_EN
        check("emptyrw_out",   bus.out, 8'h66);
`endif
        step(1'b0, 1'b1, 8'h00, 1'b0);
`ifndef SFIFO_FWFT_EN
        check("emptyrw_next",  bus.out, 8'h77);
`endif

        // flush beats a same-cycle write
        for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
        check("preclr_count", bus.count, 3);
        check("preclr_ovf",   bus.overflow, 1);
        step(1'b1, 1'b0, 8'hEE, 1'b1);
        check("clr_count", bus.count, 0);
        check("clr_empty", bus.empty, 1);
        check("clr_ovf",   bus.overflow, 0);
        check("clr_unf",   bus.underflow, 0);
        check("clr_out",   bus.out, 8'h00);

`ifdef SFIFO_FWFT_EN
        step(1'b1, 1'b0, 8'hA5, 1'b0);
        check("fwft_out",   bus.out, 8'hA5);
        check("fwft_empty", bus.empty, 0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        check("fwft_pop_empty", bus.empty, 1);
`endif

        // asynchronous reset in the middle of a burst
        step(1'b1, 1'b0, 8'h91, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h92, 1'b0);
        bus.wen  = 1'b1;
        bus.data = 8'h93;
        @(posedge clk);
        model_edge(1'b1, 1'b0, 8'h93, 1'b0);
        #2 rst = 1'b0;
        model_reset();
        #1;
        check("arst_count", bus.count, 0);
        check("arst_empty", bus.empty, 1);
        check("arst_full",  bus.full, 0);
        check("arst_out",   bus.out, 8'h00);
        check("arst_ovf",   bus.overflow, 0);
        check("arst_unf",   bus.underflow, 0);
        @(negedge clk);
        rst = 1'b1;

        // randomized traffic alternating write-heavy and read-heavy phases
        for (int unsigned ph = 0; ph < 12; ph++) begin
            pw = (ph % 2 == 0) ? 80 : 25;
            pr = (ph % 2 == 0) ? 25 : 80;
            for (int unsigned n = 0; n < 40; n++) begin
                step($urandom_range(0, 99) < pw,
                     $urandom_range(0, 99) < pr,
                     8'($urandom),
                     $urandom_range(0, 99) == 0);
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
